// File: rtl/fifo_pkg.sv
// Shared defaults for the FIFO read-side packer and its lane-index width helper.
// No logic; constants and a constant function only.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_PACK_RATIO = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Purpose: 2-entry valid/ready output buffer exposing its occupancy.
// Latency: a word pushed at an edge is presented as valid from the next cycle.
// Backpressure: holds up to two words; the writer must never push when count_o==2 without a pop.
module stream_skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] slot0_q;
  logic [WIDTH-1:0] slot1_q;
  logic [1:0]       cnt_q;
  logic             pop;

  assign pop         = (cnt_q != 2'd0) && out_ready_i;
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = slot0_q;
  assign count_o     = cnt_q;

  // slot0 is always the head; simultaneous push and pop keeps the count and order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      case ({in_valid_i, pop})
        2'b10: begin
          if (cnt_q == 2'd0) slot0_q <= in_data_i;
          else               slot1_q <= in_data_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          slot0_q <= slot1_q;
          cnt_q   <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            slot0_q <= in_data_i;
          end else begin
            slot0_q <= slot1_q;
            slot1_q <= in_data_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_packer.sv
// Purpose: pops FIFO entries and packs PACK_RATIO of them per output word (lane 0 = first popped).
// Latency: last entry popped at cycle t -> m_valid_o at t+2 when the output buffer is empty.
// Backpressure: pops are throttled so a completed word always has a free output slot; optional
// idle flush of partial words with FIFO_STREAM_PACKER_TIMEOUT_EN.
module fifo_stream_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH     = FIFO_DATA_WIDTH,
  parameter int PACK_RATIO     = FIFO_PACK_RATIO,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]            fifo_rd_data_i,
  output logic                             fifo_rd_en_o,
  output logic                             m_valid_o,
  input  logic                             m_ready_i,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data_o,
  output logic [PACK_RATIO-1:0]            m_keep_o
);

  localparam int WW = DATA_WIDTH * PACK_RATIO;
  localparam int LW = clog2(PACK_RATIO);
  localparam int NW = clog2(PACK_RATIO + 1);

  if (PACK_RATIO < 2 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_cfg
    $error("fifo_stream_packer: unsupported parameter set");
  end

  logic [LW-1:0] lane_q;
  logic          inflight_q;
  logic [WW-1:0] acc_q;
  logic [WW-1:0] cap_word;
  logic [NW-1:0] fill;
  logic [1:0]    out_cnt;
  logic          pop_ok;
  logic          rd_en;
  logic          last_lane;
  logic          flush;
  logic          push_vld;
  logic [WW-1:0] push_dat;

  // fill counts lanes already captured plus the one pop whose data is still on the way
  always_comb begin
    fill   = NW'(lane_q) + NW'(inflight_q);
    pop_ok = !fifo_empty_i && (fill < NW'(PACK_RATIO)) &&
             ((out_cnt == 2'd0) || ((out_cnt == 2'd1) && (fill < NW'(PACK_RATIO - 1))));
    rd_en  = pop_ok && !flush && !rst_i;
  end

  assign fifo_rd_en_o = rd_en;
  assign last_lane    = inflight_q && (lane_q == LW'(PACK_RATIO - 1));

  always_comb begin
    cap_word = acc_q;
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (lane_q == LW'(i)) cap_word[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q     <= '0;
      inflight_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      inflight_q <= rd_en;
      if (last_lane || flush) begin
        lane_q <= '0;
        acc_q  <= '0;
      end else if (inflight_q) begin
        lane_q <= lane_q + 1'b1;
        acc_q  <= cap_word;
      end
    end
  end

`ifdef FIFO_STREAM_PACKER_TIMEOUT_EN
  localparam int BW = WW + PACK_RATIO;

  logic [15:0]           idle_q;
  logic [PACK_RATIO-1:0] part_keep;
  logic [PACK_RATIO-1:0] push_keep;
  logic [BW-1:0]         buf_in;
  logic [BW-1:0]         buf_out;

  always_comb begin
    flush = (lane_q != '0) && !inflight_q && (idle_q == 16'(TIMEOUT_CYCLES - 1)) &&
            (out_cnt != 2'd2);
    part_keep = '0;
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (LW'(i) < lane_q) part_keep[i] = 1'b1;
    end
  end

  // Saturates at the flush threshold so a full output buffer just delays the flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_q <= '0;
    end else if (rd_en || inflight_q || flush || (lane_q == '0)) begin
      idle_q <= '0;
    end else if (idle_q != 16'(TIMEOUT_CYCLES - 1)) begin
      idle_q <= idle_q + 16'd1;
    end
  end

  always_comb begin
    push_vld  = last_lane;
    push_dat  = cap_word;
    push_keep = '1;
    if (flush) begin
      push_vld  = 1'b1;
      push_dat  = acc_q;
      push_keep = part_keep;
    end
  end

  assign buf_in   = {push_keep, push_dat};
  assign m_data_o = buf_out[WW-1:0];
  assign m_keep_o = m_valid_o ? buf_out[BW-1:WW] : '0;
`else
  localparam int BW = WW;

  logic [BW-1:0] buf_in;
  logic [BW-1:0] buf_out;

  assign flush    = 1'b0;
  assign push_vld = last_lane;
  assign push_dat = cap_word;
  assign buf_in   = push_dat;
  assign m_data_o = buf_out;
  assign m_keep_o = {PACK_RATIO{m_valid_o}};
`endif

  stream_skid_buffer #(
    .WIDTH(BW)
  ) u_out_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (push_vld),
    .in_data_i   (buf_in),
    .out_valid_o (m_valid_o),
    .out_ready_i (m_ready_i),
    .out_data_o  (buf_out),
    .count_o     (out_cnt)
  );

endmodule

// File: tb/tb_fifo_stream_packer.sv
// Bench for fifo_stream_packer with a behavioural 8-deep FIFO upstream (1-cycle read latency).
// Honours FIFO_STREAM_PACKER_TIMEOUT_EN to select the expected partial-word behaviour.
module tb_fifo_stream_packer;

  localparam int DW    = 8;
  localparam int PR    = 4;
  localparam int TO    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [31:0]   m_data;
  logic [3:0]    m_keep;

  always #5 clk = ~clk;

  fifo_stream_packer #(
    .DATA_WIDTH(DW), .PACK_RATIO(PR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .fifo_empty_i(fifo_empty), .fifo_rd_data_i(fifo_rd_data),
    .fifo_rd_en_o(rd_en), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_data_o(m_data), .m_keep_o(m_keep)
  );

  int compared = 0;
  int mismatched = 0;

  logic [7:0]  fq[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_bytes[$];
  logic [31:0] rx_data[$];
  logic [3:0]  rx_keep[$];
  int          fifo_count = 0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_byte = '0;
  int          wr_gap = 0, gap_cnt = 0;
  bit          rand_gap = 0, rand_ready = 0;
  int          cycle = 0, pops = 0, last_pop_cycle = 0;
  int          valid_cycles = 0, first_valid_cycle = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Upstream FIFO model: registered read data one cycle after the pop strobe.
  always @(posedge clk) begin
    if (rd_en) begin
      pops++;
      last_pop_cycle = cycle;
      if (fq.size() > 0) fifo_rd_data <= fq.pop_front();
    end
    if (wr_en && fq.size() < DEPTH) begin
      fq.push_back(wr_byte);
      exp_bytes.push_back(wr_byte);
    end
    fifo_empty <= (fq.size() == 0);
    fifo_count <= fq.size();
    cycle = cycle + 1;
  end

  // Writer and optional random ready, driven just after the active edge.
  always @(posedge clk) begin
    #1;
    wr_en = 1'b0;
    if (gap_cnt > 0) begin
      gap_cnt--;
    end else if (tx_q.size() > 0 && fifo_count < DEPTH) begin
      wr_en   = 1'b1;
      wr_byte = tx_q.pop_front();
      gap_cnt = rand_gap ? int'($urandom_range(0, 3)) : wr_gap;
    end
    if (rand_ready) m_ready = ($urandom_range(0, 1) == 1);
  end

  // Output monitor on the falling edge: protocol checks and word capture.
  logic        pv = 1'b0, pr = 1'b0;
  logic [31:0] pd = '0;
  logic [3:0]  pk = '0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("rd_en_while_empty", rd_en & fifo_empty, 0);
      if (pv && !pr) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, pd);
        chk("hold_keep", m_keep, pk);
      end
      if (m_valid) begin
        valid_cycles++;
        if (first_valid_cycle < 0) first_valid_cycle = cycle;
      end
      if (m_valid && m_ready) begin
        rx_data.push_back(m_data);
        rx_keep.push_back(m_keep);
      end
    end
    pv = m_valid && !rst;
    pr = m_ready;
    pd = m_data;
    pk = m_keep;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int k = 0;
    while (rx_data.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #2;
    chk({name, "_arrived"}, rx_data.size() >= n, 1);
  endtask

  function automatic logic [31:0] pop_word();
    return (rx_data.size() > 0) ? rx_data.pop_front() : 32'hxxxxxxxx;
  endfunction

  function automatic logic [3:0] pop_keep();
    return (rx_keep.size() > 0) ? rx_keep.pop_front() : 4'hx;
  endfunction

  // Reference: consecutive groups of four pushed bytes, first byte in the LSBs.
  task automatic check_words(input int n, input string name);
    for (int w = 0; w < n; w++) begin
      logic [31:0] e;
      e = '0;
      for (int b = 0; b < 4; b++) begin
        if (exp_bytes.size() > 0) e[b*8 +: 8] = exp_bytes.pop_front();
      end
      chk(name, pop_word(), e);
      chk({name, "_keep"}, pop_keep(), 4'hF);
    end
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int          spacing;
    logic [31:0] exp_word;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #400000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 1, 32'h04030201};
    tbl[1] = '{8'h05, 8'h06, 8'h07, 8'h08, 1, 32'h08070605};
    tbl[2] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 5, 32'hEFBEADDE};
    tbl[3] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 3, 32'hFF00FF00};
    tbl[4] = '{8'h80, 8'h7F, 8'h01, 8'hFE, 2, 32'hFE017F80};

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_keep", m_keep, 0);
    cyc(2);
    rst = 1'b0;

    // Table vectors: full words at various write spacings, ready held high
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      first_valid_cycle = -1;
      wr_gap = tbl[i].spacing - 1;
      tx_q.push_back(tbl[i].b0);
      tx_q.push_back(tbl[i].b1);
      tx_q.push_back(tbl[i].b2);
      tx_q.push_back(tbl[i].b3);
      wait_words(1, 100, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_data", i), pop_word(), tbl[i].exp_word);
      chk($sformatf("vec%0d_keep", i), pop_keep(), 4'hF);
      chk($sformatf("vec%0d_latency", i), 64'(first_valid_cycle - last_pop_cycle), 2);
      cyc(8);
      chk($sformatf("vec%0d_no_extra", i), rx_data.size(), 0);
      chk($sformatf("vec%0d_valid_low", i), m_valid, 0);
      exp_bytes.delete();
    end

    // Backpressure: one word buffered plus three lanes, then the FIFO fills
    m_ready = 1'b0;
    wr_gap = 0;
    pops = 0;
    for (int i = 0; i < 16; i++) tx_q.push_back(8'(8'h20 + i));
    cyc(40);
    chk("bp_pops", pops, 7);
    chk("bp_fifo_full", fifo_count, DEPTH);
    chk("bp_rd_en_low", rd_en, 0);
    chk("bp_valid", m_valid, 1);
    m_ready = 1'b1;
    wait_words(4, 100, "bp");
    check_words(4, "bp_word");
    cyc(8);
    chk("bp_all_bytes", exp_bytes.size(), 0);
    chk("bp_no_extra", rx_data.size(), 0);

    // Partial word followed by idle
    first_valid_cycle = -1;
    valid_cycles = 0;
    tx_q.push_back(8'hA1);
    tx_q.push_back(8'hA2);
    tx_q.push_back(8'hA3);
`ifdef FIFO_STREAM_PACKER_TIMEOUT_EN
    wait_words(1, 60, "to");
    chk("to_data", pop_word(), 32'h00A3A2A1);
    chk("to_keep", pop_keep(), 4'b0111);
    chk("to_delay", 64'(first_valid_cycle - last_pop_cycle), TO + 2);
`else
    cyc(60);
    chk("to_no_valid", valid_cycles, 0);
    chk("to_no_word", rx_data.size(), 0);
`endif
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    exp_bytes.delete();

    // Reset mid-word discards the partial lanes
    tx_q.push_back(8'h55);
    tx_q.push_back(8'h66);
    cyc(8);
    chk("mid_no_valid", m_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rd_en", rd_en, 0);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_keep", m_keep, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_bytes.delete();
    rx_data.delete();
    rx_keep.delete();
    for (int i = 0; i < 4; i++) tx_q.push_back(8'(8'h10 + i));
    wait_words(1, 60, "post_rst");
    chk("post_rst_data", pop_word(), 32'h13121110);
    chk("post_rst_keep", pop_keep(), 4'hF);
    cyc(8);
    chk("post_rst_no_extra", rx_data.size(), 0);
    exp_bytes.delete();

    // Random bytes, random write spacing and random ready
    rand_gap = 1;
    rand_ready = 1;
    for (int i = 0; i < 256; i++) tx_q.push_back(8'($urandom));
    wait_words(64, 5000, "rand");
    rand_ready = 0;
    rand_gap = 0;
    m_ready = 1'b1;
    check_words(64, "rand_word");
    cyc(10);
    chk("rand_all_bytes", exp_bytes.size(), 0);
    chk("rand_no_extra", rx_data.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
